// File: rtl/izqader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : izqader_pkg
//  Description : Shared definitions for the left-to-right iterative parity
//                network: FSM state encoding and the f_mid initial value.
//  Revision    : 1.0 - initial release
// ============================================================================
package izqader_pkg;

  typedef logic [1:0] state_t;

  // Sequencer states; 2'd3 is unused and recovers to IDLE
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t FINAL = 2'd2;

  // Value of f_mid before the first middle cell
  localparam logic F_MID_INIT = 1'b0;

endpackage : izqader_pkg
`default_nettype wire

// File: rtl/celda_final.sv
`default_nettype none
// ============================================================================
//  Module      : celda_final
//  Description : Final cell of the parity network. The network result is the
//                intermediate signal itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module celda_final (
  input  logic f_mid_in,
  output logic f
);

  assign f = f_mid_in;

endmodule : celda_final
`default_nettype wire

// File: rtl/celda_media.sv
`default_nettype none
// ============================================================================
//  Module      : celda_media
//  Description : Middle cell of the parity network. Folds one input bit into
//                the running intermediate signal.
//  Revision    : 1.0 - initial release
// ============================================================================
module celda_media (
  input  logic f_mid_in,
  input  logic x,
  output logic f_mid_out
);

  assign f_mid_out = f_mid_in ^ x;

endmodule : celda_media
`default_nettype wire

// File: rtl/control_serie_izqader.sv
`default_nettype none
// ============================================================================
//  Module      : control_serie_izqader
//  Description : Bit-serial sequencer for the parity network. One shared
//                middle cell is evaluated per clock, MSB first, with f_mid
//                held in a register; the final cell then updates f and
//                pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_serie_izqader
  import izqader_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         f
);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_f_mid;
  logic          r_f;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic          w_shift;
  logic          w_fin;
  logic          w_f_mid_next;
  logic          w_f_final;

  // The single middle cell, reused on every SHIFT cycle
  celda_media u_celda_media (
    .f_mid_in  (r_f_mid),
    .x         (r_sh[N-1]),
    .f_mid_out (w_f_mid_next)
  );

  celda_final u_celda_final (
    .f_mid_in (r_f_mid),
    .f        (w_f_final)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = start ? SHIFT : IDLE;
      SHIFT:   w_state_next = (r_cnt == '0) ? FINAL : SHIFT;
      FINAL:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state
  always_comb begin
    w_load  = (r_state == IDLE) && start;
    w_shift = (r_state == SHIFT);
    w_fin   = (r_state == FINAL);
  end

  // Datapath: shift register, bit counter, f_mid, result and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_f_mid <= F_MID_INIT;
      r_f     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= w_fin;
      if (w_load) begin
        r_sh    <= data_in;
        r_cnt   <= C_CNT_LAST;
        r_f_mid <= F_MID_INIT;
      end else if (w_shift) begin
        r_f_mid <= w_f_mid_next;
        r_sh    <= r_sh << 1;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (w_fin) begin
        r_f <= w_f_final;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign f    = r_f;

endmodule : control_serie_izqader
`default_nettype wire
